// File: rtl/if_pc_gen_pkg.sv
// if_pc_gen_pkg: shared address width, fetch FSM states and next-pc source encoding
package if_pc_gen_pkg;
  localparam int ADDR_WIDTH = 32;
  typedef enum logic {BOOT, RUN} state_e;
  typedef enum logic [2:0] {SRC_TRAP, SRC_EX, SRC_DEC, SRC_STALL, SRC_PRED, SRC_SEQ} src_e;
  function automatic src_e sel_src(input logic trap, ex, dec, stall, pred);
    return trap ? SRC_TRAP : ex ? SRC_EX : dec ? SRC_DEC : stall ? SRC_STALL : pred ? SRC_PRED : SRC_SEQ;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rstn,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge cpu_clk or negedge cpu_rstn)
    if (!cpu_rstn) count <= '0;
    else if (inc && !(&count)) count <= count + WIDTH'(1);
endmodule

// File: rtl/if_pc_gen.sv
// if_pc_gen: fetch pc generator with redirect priority, predictor qualification and perf counters
module if_pc_gen import if_pc_gen_pkg::*; #(
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int                    CNT_WIDTH    = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  stall_if,
  input  logic                  predict_taken,
  input  logic [ADDR_WIDTH-1:0] predict_target_pc,
  input  logic                  trap_enter,
  input  logic [ADDR_WIDTH-1:0] trap_vector,
  input  logic                  mispredict_ex,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_ex,
  input  logic                  jal_dec,
  input  logic [ADDR_WIDTH-1:0] jal_target_dec,
  input  logic                  branch_ex,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  pc_valid,
  output logic                  predict_taken_if,
  output logic                  flush_if,
  output logic [CNT_WIDTH-1:0]  cnt_branch,
  output logic [CNT_WIDTH-1:0]  cnt_mispredict
);
  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_target;
  logic                  r_pc_valid;
  src_e                  w_src;

  always_ff @(posedge cpu_clk or negedge cpu_rstn)
    if (!cpu_rstn) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VECTOR;
      r_pc_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= next_pc;
      r_pc_valid <= 1'b1;
    end

  // Async reset forces BOOT, so every output below takes its BOOT value while reset is held
  always_comb begin
    w_state_nxt      = (r_state == BOOT) ? RUN : r_state;
    flush_if         = (r_state == RUN) & (trap_enter | mispredict_ex | jal_dec);
    predict_taken_if = (r_state == RUN) & predict_taken & r_pc_valid & ~flush_if;
    w_src            = sel_src(trap_enter, mispredict_ex, jal_dec, stall_if, predict_taken_if);
    w_target         = (w_src == SRC_TRAP)  ? trap_vector :
                       (w_src == SRC_EX)    ? redirect_pc_ex :
                       (w_src == SRC_DEC)   ? jal_target_dec :
                       (w_src == SRC_STALL) ? r_pc :
                       (w_src == SRC_PRED)  ? predict_target_pc :
                                              r_pc + ADDR_WIDTH'(4);
    next_pc          = (r_state == BOOT) ? RESET_VECTOR : (w_target & ~ADDR_WIDTH'(3));
  end

  assign pc       = r_pc;
  assign pc_valid = r_pc_valid;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_branch (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .inc(branch_ex), .count(cnt_branch)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_mispredict (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .inc(mispredict_ex), .count(cnt_mispredict)
  );
endmodule
